signed_sum_acc: RTL and testbench

Windowed signed accumulator placed directly downstream of the signed adder stage. It consumes the 9-bit signed sum stream and its valid. It accumulates a fixed window of 2^LOG2_LEN valid samples with saturation, then emits the window total, its arithmetic mean and an overflow flag as a one-cycle result strobe. It also provides a synchronous clear so the host can restart a window.

---
 rtl/signed_acc_pkg.sv | 18 +
 rtl/sat_clip.sv | 30 +++
 rtl/signed_sum_acc.sv | 111 +++++++++++
 tb/tb_signed_sum_acc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_acc_pkg.sv
// rtl/signed_acc_pkg.sv - shared widths, defaults and saturation bounds for the signed window accumulator
package signed_acc_pkg;

  localparam int DIN_W        = 9;
  localparam int DEF_LOG2_LEN = 3;
  localparam int DEF_ACC_W    = 16;

  // Largest value representable in a w-bit two's complement word
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_clip.sv
// rtl/sat_clip.sv - combinational signed saturating narrower with overflow flag
module sat_clip
  import signed_acc_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  // Bounds expressed at the input width so the compare is a plain signed compare
  localparam logic signed [IN_W-1:0] HI = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] LO = IN_W'(sat_min(OUT_W));

  // Clamp to the output range; flag whenever the value had to move
  always_comb begin
    dout = din[OUT_W-1:0];
    ovf  = 1'b0;
    if (din > HI) begin
      dout = OUT_W'(HI);
      ovf  = 1'b1;
    end else if (din < LO) begin
      dout = OUT_W'(LO);
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/signed_sum_acc.sv
// rtl/signed_sum_acc.sv - windowed saturating accumulator reporting total, mean and overflow
module signed_sum_acc
  import signed_acc_pkg::*;
#(
  parameter int LOG2_LEN = DEF_LOG2_LEN,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    din_vld,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] dout,
  output logic signed [DIN_W-1:0] dout_mean,
  output logic                    dout_vld,
  output logic                    ovf
);

  logic        [LOG2_LEN-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       ovf_st_q, ovf_st_d;
  logic signed [ACC_W-1:0]    dout_q, dout_d;
  logic signed [DIN_W-1:0]    mean_q, mean_d;
  logic                       vld_q, vld_d;
  logic                       ovf_q, ovf_d;

  logic signed [ACC_W:0]      acc_base;
  logic signed [ACC_W:0]      raw;
  logic signed [ACC_W-1:0]    sat;
  logic                       step_ovf;
  logic signed [ACC_W-1:0]    mean_in;
  logic signed [DIN_W-1:0]    mean_sat;
  logic                       mean_clip_unused;
  logic                       last;

  // One guard bit above the accumulator so a single step can never wrap before clipping
  always_comb begin
    acc_base = (cnt_q == '0) ? '0 : (ACC_W + 1)'(acc_q);
    raw      = acc_base + (ACC_W + 1)'(din);
    mean_in  = sat >>> LOG2_LEN;
    last     = (cnt_q == {LOG2_LEN{1'b1}});
  end

  sat_clip #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_acc_clip (
    .din  (raw),
    .dout (sat),
    .ovf  (step_ovf)
  );

  sat_clip #(.IN_W(ACC_W), .OUT_W(DIN_W)) u_mean_clip (
    .din  (mean_in),
    .dout (mean_sat),
    .ovf  (mean_clip_unused)
  );

  // Next-state: clear beats a sample; the last sample of a window publishes the result
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_st_d = ovf_st_q;
    dout_d   = dout_q;
    mean_d   = mean_q;
    ovf_d    = ovf_q;
    vld_d    = 1'b0;
    if (clr) begin
      cnt_d    = '0;
      acc_d    = '0;
      ovf_st_d = 1'b0;
    end else if (din_vld) begin
      if (last) begin
        dout_d   = sat;
        mean_d   = mean_sat;
        ovf_d    = ovf_st_q | step_ovf;
        vld_d    = 1'b1;
        cnt_d    = '0;
        ovf_st_d = 1'b0;
      end else begin
        acc_d    = sat;
        ovf_st_d = ovf_st_q | step_ovf;
        cnt_d    = cnt_q + LOG2_LEN'(1);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_st_q <= 1'b0;
      dout_q   <= '0;
      mean_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_st_q <= ovf_st_d;
      dout_q   <= dout_d;
      mean_q   <= mean_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dout      = dout_q;
  assign dout_mean = mean_q;
  assign dout_vld  = vld_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_sum_acc.sv
// tb/tb_signed_sum_acc.sv - scoreboard bench for signed_sum_acc at ACC_W 16 and 10
module tb_signed_sum_acc;

  localparam int LEN = 8;

  typedef struct {
    longint tot;
    longint mean;
    bit     ovf;
    int     due;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic signed [8:0]  din;
  logic               din_vld;
  logic               clr;

  logic signed [15:0] dout16;
  logic signed [8:0]  mean16;
  logic               vld16;
  logic               ovf16;
  logic signed [9:0]  dout10;
  logic signed [8:0]  mean10;
  logic               vld10;
  logic               ovf10;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t   q16[$];
  exp_t   q10[$];
  longint m_acc[2];
  int     m_cnt[2];
  bit     m_ovf[2];
  int     aw[2] = '{16, 10};

  signed_sum_acc u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .clr       (clr),
    .dout      (dout16),
    .dout_mean (mean16),
    .dout_vld  (vld16),
    .ovf       (ovf16)
  );

  signed_sum_acc #(.LOG2_LEN(3), .ACC_W(10)) u_dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .clr       (clr),
    .dout      (dout10),
    .dout_mean (mean10),
    .dout_vld  (vld10),
    .ovf       (ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_sample(input int d);
    longint base, raw, sat, hi, lo, mean;
    bit     o;
    exp_t   e;
    for (int k = 0; k < 2; k++) begin
      hi   = (longint'(1) << (aw[k] - 1)) - 1;
      lo   = -hi - 1;
      base = (m_cnt[k] == 0) ? 0 : m_acc[k];
      raw  = base + d;
      sat  = (raw > hi) ? hi : ((raw < lo) ? lo : raw);
      o    = (raw != sat);
      if (m_cnt[k] < LEN - 1) begin
        m_acc[k] = sat;
        m_ovf[k] = m_ovf[k] | o;
        m_cnt[k] = m_cnt[k] + 1;
      end else begin
        mean = (sat >= 0) ? sat / LEN : -((-sat + LEN - 1) / LEN);
        if (mean > 255) mean = 255;
        if (mean < -256) mean = -256;
        e.tot  = sat;
        e.mean = mean;
        e.ovf  = m_ovf[k] | o;
        e.due  = cyc + 1;
        if (k == 0) q16.push_back(e);
        else        q10.push_back(e);
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end
    end
  endtask

  // One clock edge, then drain whichever scoreboard entries fall due on it
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    n_vec++;
    if (q16.size() > 0 && q16[0].due == cyc) begin
      e = q16.pop_front();
      if (vld16 !== 1'b1 || longint'(dout16) !== e.tot || longint'(mean16) !== e.mean || ovf16 !== e.ovf) begin
        n_err++;
        $display("FAIL result16 cyc=%0d got vld=%b dout=%0d mean=%0d ovf=%b want vld=1 dout=%0d mean=%0d ovf=%b",
                 cyc, vld16, dout16, mean16, ovf16, e.tot, e.mean, e.ovf);
      end
    end else if (vld16 !== 1'b0) begin
      n_err++;
      $display("FAIL stray_vld16 cyc=%0d got vld=%b want 0", cyc, vld16);
    end
    n_vec++;
    if (q10.size() > 0 && q10[0].due == cyc) begin
      e = q10.pop_front();
      if (vld10 !== 1'b1 || longint'(dout10) !== e.tot || longint'(mean10) !== e.mean || ovf10 !== e.ovf) begin
        n_err++;
        $display("FAIL result10 cyc=%0d got vld=%b dout=%0d mean=%0d ovf=%b want vld=1 dout=%0d mean=%0d ovf=%b",
                 cyc, vld10, dout10, mean10, ovf10, e.tot, e.mean, e.ovf);
      end
    end else if (vld10 !== 1'b0) begin
      n_err++;
      $display("FAIL stray_vld10 cyc=%0d got vld=%b want 0", cyc, vld10);
    end
  endtask

  task automatic apply(input bit v, input int d, input bit c);
    din     = 9'(d);
    din_vld = v;
    clr     = c;
    if (c)      model_clear();
    else if (v) model_sample(d);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    din     = '0;
    din_vld = 1'b0;
    clr     = 1'b0;
    model_clear();
    tick();
    tick();
    n_vec++;
    if (dout16 !== 16'sd0 || mean16 !== 9'sd0 || vld16 !== 1'b0 || ovf16 !== 1'b0) begin
      n_err++;
      $display("FAIL reset16 got dout=%0d mean=%0d vld=%b ovf=%b want all 0", dout16, mean16, vld16, ovf16);
    end
    n_vec++;
    if (dout10 !== 10'sd0 || mean10 !== 9'sd0 || vld10 !== 1'b0 || ovf10 !== 1'b0) begin
      n_err++;
      $display("FAIL reset10 got dout=%0d mean=%0d vld=%b ovf=%b want all 0", dout10, mean10, vld10, ovf10);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * LEN; i++) apply(1'b1, 255, 1'b0);
    idle(2);
  endtask

  task automatic test_neg_gaps();
    for (int i = 0; i < LEN; i++) begin
      idle($urandom_range(0, 3));
      apply(1'b1, -256, 1'b0);
    end
    idle(2);
  endtask

  task automatic test_sticky_ovf();
    for (int i = 0; i < LEN; i++) apply(1'b1, 255, 1'b0);
    for (int i = 0; i < LEN; i++) apply(1'b1, 1, 1'b0);
    idle(2);
  endtask

  task automatic test_mean_floor();
    apply(1'b1, -1, 1'b0);
    for (int i = 1; i < LEN; i++) apply(1'b1, 0, 1'b0);
    idle(2);
  endtask

  task automatic test_clr();
    for (int i = 0; i < 5; i++) apply(1'b1, 10, 1'b0);
    apply(1'b0, 0, 1'b1);
    for (int i = 0; i < LEN; i++) apply(1'b1, 10, 1'b0);
    idle(2);
    for (int i = 0; i < LEN - 1; i++) apply(1'b1, 10, 1'b0);
    apply(1'b1, 10, 1'b1);
    idle(3);
    n_vec++;
    if (dout16 !== 16'sd80 || mean16 !== 9'sd10 || ovf16 !== 1'b0) begin
      n_err++;
      $display("FAIL clr_hold got dout=%0d mean=%0d ovf=%b want dout=80 mean=10 ovf=0", dout16, mean16, ovf16);
    end
    for (int i = 0; i < LEN; i++) apply(1'b1, 10, 1'b0);
    idle(2);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) apply(1'b1, 5, 1'b0);
    din_vld = 1'b0;
    rst_n   = 1'b0;
    model_clear();
    #2;
    n_vec++;
    if (dout16 !== 16'sd0 || mean16 !== 9'sd0 || vld16 !== 1'b0 || ovf16 !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst16 got dout=%0d mean=%0d vld=%b ovf=%b want all 0", dout16, mean16, vld16, ovf16);
    end
    n_vec++;
    if (dout10 !== 10'sd0 || mean10 !== 9'sd0 || vld10 !== 1'b0 || ovf10 !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst10 got dout=%0d mean=%0d vld=%b ovf=%b want all 0", dout10, mean10, vld10, ovf10);
    end
    tick();
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < LEN; i++) apply(1'b1, 3, 1'b0);
    idle(2);
  endtask

  task automatic test_drained();
    n_vec++;
    if (q16.size() != 0 || q10.size() != 0) begin
      n_err++;
      $display("FAIL drained got pending16=%0d pending10=%0d want 0 and 0", q16.size(), q10.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_neg_gaps();
    test_sticky_ovf();
    test_mean_floor();
    test_clr();
    test_rst_mid();
    test_drained();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
